sar_ctrl: RTL and testbench
===========================

SAR_CTRL -- requirements
Module: sar_ctrl

Interface
REQ-001 Parameter: NBITS, 12, conversion resolution in bits; also the width of DAC_CODE and RESULT.
REQ-002 Parameter: SAMPLE_CYCLES, 2, number of clock cycles SAMPLE is held high per conversion; legal range 1..15.
REQ-003 Port: CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port: RST_N  input  1  asynchronous, active-low reset.
REQ-005 Port: START  input  1  conversion request, level-sampled on CLK.
REQ-006 Port: ABORT  input  1  synchronous abort of the conversion in progress.
REQ-007 Port: COMP  input  1  comparator decision; 1 = Vin >= Vdac(DAC_CODE).
REQ-008 Port: SAMPLE  output  1  track/hold switch control; 1 = track.
REQ-009 Port: DAC_CODE  output  NBITS  trial code driven to the capacitive DAC.
REQ-010 Port: RESULT  output  NBITS  last completed conversion code.
REQ-011 Port: VALID  output  1  one-cycle strobe marking a new RESULT.
REQ-012 Port: BUSY  output  1  high in the SAMPLE, CONV and DONE states.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SAMP, CONV and DONE.
REQ-014 In IDLE with START=1, the FSM SHALL go to SAMP, load the sample counter with SAMPLE_CYCLES-1, and set DAC_CODE to 0.
REQ-015 In SAMP, SAMPLE SHALL be 1 for exactly SAMPLE_CYCLES consecutive cycles, after which the FSM SHALL enter CONV.
REQ-016 On entry to CONV:
- DAC_CODE SHALL be 1 followed by NBITS-1 zeros (MSB trial).
- A one-hot bit pointer SHALL select the MSB.
REQ-017 On each CONV cycle, the bit under the pointer SHALL keep its value if COMP=1 and be cleared if COMP=0.
REQ-018 On the same CONV cycle, the next lower bit SHALL be set as the new trial bit and the pointer SHALL shift one position toward the LSB.
REQ-019 CONV SHALL last exactly NBITS cycles, with the LSB decided on the last of these cycles.
REQ-020 On the transition from the last CONV cycle to DONE, RESULT SHALL load the final code, with the LSB decision from COMP already applied.
REQ-021 In DONE, VALID SHALL be 1 for exactly that one cycle.
REQ-022 From DONE, the FSM SHALL return to IDLE, or go directly to SAMP if START=1 (back-to-back conversion).
REQ-023 Latency: with START accepted at edge 0, SAMPLE SHALL be high for cycles 1..SAMPLE_CYCLES, CONV SHALL occupy the following NBITS cycles, and VALID SHALL be high in cycle SAMPLE_CYCLES+NBITS+1.
REQ-024 START while in SAMP or CONV SHALL be ignored; it is not queued.
REQ-025 ABORT=1 in SAMP or CONV SHALL force IDLE on the next edge:
- SAMPLE=0 and DAC_CODE=0.
- No VALID is produced.
- RESULT is unchanged.
REQ-026 ABORT in IDLE or DONE SHALL have no effect.
REQ-027 If ABORT and START are both 1 in IDLE or DONE, START SHALL win.
REQ-028 RESULT SHALL change only on the transition into DONE.
REQ-029 DAC_CODE SHALL hold its final value during DONE and SHALL clear to 0 on entry to IDLE.
REQ-030 BUSY SHALL be 0 only in IDLE.
REQ-031 SAMPLE SHALL be 0 in every state except SAMP.
REQ-032 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-033 RST_N=0 SHALL immediately, without waiting for CLK, force:
- state to IDLE;
- SAMPLE, VALID and BUSY to 0;
- DAC_CODE and RESULT to 0;
- the bit pointer and sample counter to 0.
REQ-034 Assertion of RST_N in any state, including mid-CONV, SHALL discard the conversion in progress without producing VALID.
REQ-035 After RST_N deasserts, the first START SHALL be accepted on the first rising edge at which it is sampled high.

Verification
REQ-036 Reset scenario: pulse RST_N low asynchronously, between clock edges, mid-CONV -> all outputs are 0 before the next edge, and no VALID appears.
REQ-037 Ideal comparator scenario: model COMP = (0xA5C >= DAC_CODE), NBITS=12, SAMPLE_CYCLES=2, one START pulse -> SAMPLE high for cycles 1-2, RESULT=0xA5C, VALID high in cycle 15 only.
REQ-038 Extreme-code scenario: COMP held at 1 -> RESULT=0xFFF; COMP held at 0 -> RESULT=0x000; in both cases DAC_CODE is 0x800 in the first CONV cycle.
REQ-039 Back-to-back scenario: START held high continuously -> successive VALID strobes exactly 15 cycles apart, and START pulses issued during SAMP/CONV are ignored.
REQ-040 Abort scenario: ABORT in the 5th CONV cycle -> IDLE next cycle, no VALID, RESULT keeps its prior value, and a subsequent START converts normally.
REQ-041 Priority scenario: START and ABORT both high in IDLE -> the FSM enters SAMP.

Source files
------------

// File: rtl/sar_ctrl.sv
// Successive-approximation ADC controller: sample/hold sequencing, binary search of the DAC
// code one bit per cycle, and a registered result with a one-cycle VALID strobe.
module sar_ctrl #(
  parameter int unsigned NBITS         = 12,
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic             COMP,
  output logic             SAMPLE,
  output logic [NBITS-1:0] DAC_CODE,
  output logic [NBITS-1:0] RESULT,
  output logic             VALID,
  output logic             BUSY
);

  typedef enum logic [1:0] {StIdle, StSamp, StConv, StDone} state_e;

  localparam logic [3:0]       CntLoad = 4'(SAMPLE_CYCLES - 1);
  localparam logic [NBITS-1:0] MsbOnly = {1'b1, {(NBITS-1){1'b0}}};

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NBITS-1:0] ptr_q, ptr_d;
  logic [NBITS-1:0] dac_q, dac_d;
  logic [NBITS-1:0] result_q, result_d;
  logic             sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic [NBITS-1:0] trial;

  // Resolve the bit under the pointer, then raise the next lower bit as the new trial.
  assign trial = (COMP ? dac_q : (dac_q & ~ptr_q)) | (ptr_q >> 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    dac_d    = dac_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StSamp;
          cnt_d   = CntLoad;
          dac_d   = '0;
        end
      end
      StSamp: begin
        if (ABORT) begin
          state_d = StIdle;
          cnt_d   = '0;
          dac_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = StConv;
          dac_d   = MsbOnly;
          ptr_d   = MsbOnly;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StConv: begin
        if (ABORT) begin
          state_d = StIdle;
          dac_d   = '0;
          ptr_d   = '0;
        end else begin
          dac_d = trial;
          ptr_d = ptr_q >> 1;
          if (ptr_q[0]) begin
            result_d = trial;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        // START outranks ABORT here; ABORT alone has no effect in DONE.
        dac_d = '0;
        if (START) begin
          state_d = StSamp;
          cnt_d   = CntLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        dac_d   = '0;
        ptr_d   = '0;
        cnt_d   = '0;
      end
    endcase

    sample_d = (state_d == StSamp);
    valid_d  = (state_d == StDone);
    busy_d   = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= '0;
      dac_q    <= '0;
      result_q <= '0;
      sample_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      dac_q    <= dac_d;
      result_q <= result_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
    end
  end

  assign SAMPLE   = sample_q;
  assign DAC_CODE = dac_q;
  assign RESULT   = result_q;
  assign VALID    = valid_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Scoreboard bench for sar_ctrl: expected codes are queued when a conversion is launched and
// popped when VALID strobes; per-cycle traces check SAMPLE/BUSY/VALID timing.
module tb_sar_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, comp;
  logic        ideal, comp_const;
  logic [11:0] target;
  logic        sample, valid, busy;
  logic [11:0] dac_code, result;

  int          n_checks = 0;
  int          n_pass = 0;
  int          valid_cnt = 0;
  logic [11:0] sb[$];

  logic [31:0] samp_mask, valid_mask, busy_mask;
  logic [11:0] dac_trace[0:20];
  logic [11:0] res_at_valid;

  sar_ctrl #(.NBITS(12), .SAMPLE_CYCLES(2)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .START    (start),
    .ABORT    (abort),
    .COMP     (comp),
    .SAMPLE   (sample),
    .DAC_CODE (dac_code),
    .RESULT   (result),
    .VALID    (valid),
    .BUSY     (busy)
  );

  always #5 clk = ~clk;

  // Ideal comparator against a fixed input level, or a stuck decision.
  assign comp = ideal ? (target >= dac_code) : comp_const;

  always @(negedge clk) if (valid === 1'b1) valid_cnt++;

  // Launch one conversion at edge 0 and record cycles 1..20.
  task automatic do_conv(input int abort_cyc, input bit noise);
    samp_mask = '0; valid_mask = '0; busy_mask = '0; res_at_valid = 'x;
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      samp_mask[c]  = sample;
      valid_mask[c] = valid;
      busy_mask[c]  = busy;
      dac_trace[c]  = dac_code;
      if (valid === 1'b1) res_at_valid = result;
      start = noise && (c == 2 || c == 7);
      abort = (c == abort_cyc);
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ideal = 1'b0; comp_const = 1'b0; target = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (sample !== 1'b0) $display("FAIL reset_sample got %b want 0", sample); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (dac_code !== 12'h000) $display("FAIL reset_dac got %h want 000", dac_code); else n_pass++;
    n_checks++; if (result !== 12'h000) $display("FAIL reset_result got %h want 000", result); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_ideal();
    logic [11:0] exp;
    ideal = 1'b1; target = 12'hA5C;
    sb.push_back(12'hA5C);
    do_conv(0, 1'b0);
    n_checks++; if (samp_mask !== 32'h6) $display("FAIL ideal_sample got %h want 00000006", samp_mask); else n_pass++;
    n_checks++; if (valid_mask !== 32'h8000) $display("FAIL ideal_valid got %h want 00008000", valid_mask); else n_pass++;
    n_checks++; if (busy_mask !== 32'hFFFE) $display("FAIL ideal_busy got %h want 0000fffe", busy_mask); else n_pass++;
    n_checks++; if (dac_trace[3] !== 12'h800) $display("FAIL ideal_msb_trial got %h want 800", dac_trace[3]); else n_pass++;
    n_checks++; if (dac_trace[16] !== 12'h000) $display("FAIL ideal_dac_idle got %h want 000", dac_trace[16]); else n_pass++;
    exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
    n_checks++; if (res_at_valid !== exp) $display("FAIL ideal_result got %h want %h", res_at_valid, exp); else n_pass++;
  endtask

  task automatic test_extreme();
    logic [11:0] exp;
    ideal = 1'b0;
    for (int k = 0; k < 2; k++) begin
      comp_const = (k == 0);
      sb.push_back(k == 0 ? 12'hFFF : 12'h000);
      do_conv(0, 1'b0);
      n_checks++; if (dac_trace[3] !== 12'h800) $display("FAIL extreme_msb_trial[%0d] got %h want 800", k, dac_trace[3]); else n_pass++;
      exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
      n_checks++; if (res_at_valid !== exp) $display("FAIL extreme_result[%0d] got %h want %h", k, res_at_valid, exp); else n_pass++;
      n_checks++; if (dac_trace[15] !== exp) $display("FAIL extreme_dac_hold[%0d] got %h want %h", k, dac_trace[15], exp); else n_pass++;
    end
  endtask

  task automatic test_start_ignored();
    logic [11:0] exp;
    ideal = 1'b1; target = 12'h123;
    sb.push_back(12'h123);
    do_conv(0, 1'b1);
    n_checks++; if (valid_mask !== 32'h8000) $display("FAIL ignored_valid got %h want 00008000", valid_mask); else n_pass++;
    n_checks++; if (busy_mask !== 32'hFFFE) $display("FAIL ignored_busy got %h want 0000fffe", busy_mask); else n_pass++;
    exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
    n_checks++; if (res_at_valid !== exp) $display("FAIL ignored_result got %h want %h", res_at_valid, exp); else n_pass++;
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    ideal = 1'b1; target = 12'h5A5;
    do_conv(7, 1'b0);  // cycle 7 is the 5th CONV cycle
    n_checks++; if (valid_mask !== 32'h0) $display("FAIL abort_valid got %h want 00000000", valid_mask); else n_pass++;
    n_checks++; if (busy_mask !== 32'hFE) $display("FAIL abort_busy got %h want 000000fe", busy_mask); else n_pass++;
    n_checks++; if (dac_trace[8] !== 12'h000) $display("FAIL abort_dac got %h want 000", dac_trace[8]); else n_pass++;
    n_checks++; if (result !== 12'h123) $display("FAIL abort_result_kept got %h want 123", result); else n_pass++;
    sb.push_back(12'h5A5);
    do_conv(0, 1'b0);
    n_checks++; if (valid_mask !== 32'h8000) $display("FAIL abort_after_valid got %h want 00008000", valid_mask); else n_pass++;
    exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
    n_checks++; if (res_at_valid !== exp) $display("FAIL abort_after_result got %h want %h", res_at_valid, exp); else n_pass++;
  endtask

  task automatic test_priority();
    int v0;
    v0 = valid_cnt;
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++; if (sample !== 1'b1) $display("FAIL prio_sample got %b want 1", sample); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL prio_busy got %b want 1", busy); else n_pass++;
    @(negedge clk); abort = 1'b0;
    n_checks++; if (busy !== 1'b0) $display("FAIL prio_abort_samp got %b want 0", busy); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (valid_cnt !== v0) $display("FAIL prio_no_valid got %0d want %0d", valid_cnt, v0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int pos[$];
    logic [11:0] exp;
    ideal = 1'b1; target = 12'h3C1;
    repeat (3) sb.push_back(12'h3C1);
    @(negedge clk); start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      @(negedge clk);
      if (c == 16) begin
        n_checks++; if (sample !== 1'b1) $display("FAIL b2b_resample got %b want 1", sample); else n_pass++;
      end
      if (valid === 1'b1) begin
        pos.push_back(c);
        exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
        n_checks++; if (result !== exp) $display("FAIL b2b_result@%0d got %h want %h", c, result, exp); else n_pass++;
      end
    end
    start = 1'b0;
    n_checks++; if (pos.size() !== 3) $display("FAIL b2b_count got %0d want 3", pos.size()); else n_pass++;
    if (pos.size() == 3) begin
      n_checks++; if (pos[0] !== 15) $display("FAIL b2b_first got %0d want 15", pos[0]); else n_pass++;
      n_checks++; if (pos[1] - pos[0] !== 15) $display("FAIL b2b_gap1 got %0d want 15", pos[1] - pos[0]); else n_pass++;
      n_checks++; if (pos[2] - pos[1] !== 15) $display("FAIL b2b_gap2 got %0d want 15", pos[2] - pos[1]); else n_pass++;
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int v0;
    logic [11:0] exp;
    ideal = 1'b1; target = 12'h777;
    v0 = valid_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);  // now in cycle 6, mid-CONV
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (sample !== 1'b0) $display("FAIL areset_sample got %b want 0", sample); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL areset_valid got %b want 0", valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL areset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (dac_code !== 12'h000) $display("FAIL areset_dac got %h want 000", dac_code); else n_pass++;
    n_checks++; if (result !== 12'h000) $display("FAIL areset_result got %h want 000", result); else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (valid_cnt !== v0) $display("FAIL areset_no_valid got %0d want %0d", valid_cnt, v0); else n_pass++;
    sb.push_back(12'h777);
    do_conv(0, 1'b0);
    n_checks++; if (samp_mask !== 32'h6) $display("FAIL areset_restart_sample got %h want 00000006", samp_mask); else n_pass++;
    exp = (sb.size() > 0) ? sb.pop_front() : 12'hxxx;
    n_checks++; if (res_at_valid !== exp) $display("FAIL areset_restart_result got %h want %h", res_at_valid, exp); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_extreme();
    test_start_ignored();
    test_abort();
    test_priority();
    test_back_to_back();
    test_async_reset();
    n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d want 0", sb.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
